// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet parser: FSM state encoding,
// default frame marker and checksum arithmetic.
package uart_pkg;

  // Parser states
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  // Default start-of-frame marker
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Checksum width (8-bit wrap-around sum)
  localparam int CHK_W = 8;

  // Running checksum update: modulo-2^CHK_W addition
  function automatic logic [CHK_W-1:0] chk_add(input logic [CHK_W-1:0] acc,
                                               input logic [7:0]       data);
    chk_add = acc + CHK_W'(data);
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port register array with a
// synchronous write port and a registered read port (data for the address
// presented in one cycle appears in the next).
module uart_pkt_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Storage write; contents need no reset because they are always written before being read
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read so the output byte comes straight from a flop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 8'd0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_pkt_parser.sv
// UART packet parser: finds SYNC/LEN/payload/CHK frames in the received
// byte stream, buffers the payload, verifies the 8-bit checksum and replays
// good payloads on a valid/ready byte interface.
// Optional build macro PKT_TIMEOUT_EN adds an inter-byte timeout that aborts
// partial frames and pulses o_Err_Timeout.
module uart_rx_pkt_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_LEN   = 16
`ifdef PKT_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CLKS = 4340
`endif
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Pkt_Valid,
  output logic [7:0] o_Pkt_Byte,
  output logic       o_Pkt_Last,
  input  logic       i_Pkt_Ready,
  output logic [7:0] o_Pkt_Len,
  output logic       o_Err_Chk,
  output logic       o_Err_Len,
  output logic       o_Overrun
`ifdef PKT_TIMEOUT_EN
  ,
  output logic       o_Err_Timeout
`endif
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [CHK_W-1:0] sum_q, sum_d;
  logic [7:0]       wr_idx_q, wr_idx_d;
  logic [7:0]       rd_idx_q, rd_idx_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             overrun_q, overrun_d;
  logic             buf_we_s;
  logic [7:0]       buf_rdata_s;
  logic             accept_s;
  logic             len_ok_s;

`ifdef PKT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_tmo_q, err_tmo_d;
`endif

  assign accept_s = valid_q & i_Pkt_Ready;
  assign len_ok_s = (i_RX_Byte != 8'd0) && (i_RX_Byte <= MAX_LEN_B);

  // Next-state and next-output computation for the frame parser
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    valid_d   = valid_q;
    last_d    = last_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    overrun_d = 1'b0;
    buf_we_s  = 1'b0;
`ifdef PKT_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_tmo_d = 1'b0;
`endif

    case (state_q)
      ST_HUNT: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end else begin
          state_d = ST_HUNT;
        end
      end

      ST_LEN: begin
        if (i_RX_DV) begin
          if (len_ok_s) begin
            len_d    = i_RX_Byte;
            sum_d    = CHK_W'(i_RX_Byte);
            wr_idx_d = 8'd0;
            state_d  = ST_PAYLOAD;
          end else begin
            // Rejected length byte is consumed, never re-examined as SYNC
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end else begin
          state_d = ST_LEN;
        end
      end

      ST_PAYLOAD: begin
        if (i_RX_DV) begin
          buf_we_s = 1'b1;
          sum_d    = chk_add(sum_q, i_RX_Byte);
          if (wr_idx_q == (len_q - 8'd1)) begin
            // Index is left at the last slot so it never passes MAX_LEN-1
            state_d = ST_CHECK;
          end else begin
            wr_idx_d = wr_idx_q + 8'd1;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end

      ST_CHECK: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == sum_q) begin
            rd_idx_d = 8'd0;
            valid_d  = 1'b1;
            last_d   = (len_q == 8'd1);
            state_d  = ST_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_DRAIN: begin
        // Bytes arriving while the buffer is being replayed are dropped
        if (i_RX_DV) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = 1'b0;
        end
        if (accept_s) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_HUNT;
          end else begin
            rd_idx_d = rd_idx_q + 8'd1;
            last_d   = ((rd_idx_q + 8'd2) == len_q);
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_HUNT;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

`ifdef PKT_TIMEOUT_EN
    // Inter-byte watchdog: only armed while a frame is partially received
    if ((state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK)) begin
      if (i_RX_DV) begin
        tmo_cnt_d = {TMO_W{1'b0}};
      end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
        tmo_cnt_d = {TMO_W{1'b0}};
        err_tmo_d = 1'b1;
        state_d   = ST_HUNT;
      end else begin
        tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
      end
    end else begin
      tmo_cnt_d = {TMO_W{1'b0}};
    end
`endif
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_HUNT;
      len_q     <= 8'd0;
      sum_q     <= {CHK_W{1'b0}};
      wr_idx_q  <= 8'd0;
      rd_idx_q  <= 8'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef PKT_TIMEOUT_EN
  // Timeout counter and its error pulse
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
      err_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign o_Err_Timeout = err_tmo_q;
`endif

  // Read address is the next read index so the registered read data lines up with valid
  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W)
  ) u_buf (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .we_i    (buf_we_s),
    .waddr_i (wr_idx_q[IDX_W-1:0]),
    .wdata_i (i_RX_Byte),
    .raddr_i (rd_idx_d[IDX_W-1:0]),
    .rdata_o (buf_rdata_s)
  );

  assign o_Pkt_Valid = valid_q;
  assign o_Pkt_Byte  = buf_rdata_s;
  assign o_Pkt_Last  = last_q;
  assign o_Pkt_Len   = len_q;
  assign o_Err_Chk   = err_chk_q;
  assign o_Err_Len   = err_len_q;
  assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// Scoreboard bench for uart_rx_pkt_parser: directed frames push expected
// payload bytes into a queue; a negedge monitor pops and compares on every
// accepted byte and counts error pulses.
module tb_uart_rx_pkt_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] rx_byte;
  logic       ready;
  logic       pkt_valid;
  logic [7:0] pkt_byte;
  logic       pkt_last;
  logic [7:0] pkt_len;
  logic       err_chk;
  logic       err_len;
  logic       overrun;
`ifdef PKT_TIMEOUT_EN
  logic       err_tmo;
`endif

  uart_rx_pkt_parser dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_RX_DV     (dv),
    .i_RX_Byte   (rx_byte),
    .o_Pkt_Valid (pkt_valid),
    .o_Pkt_Byte  (pkt_byte),
    .o_Pkt_Last  (pkt_last),
    .i_Pkt_Ready (ready),
    .o_Pkt_Len   (pkt_len),
    .o_Err_Chk   (err_chk),
    .o_Err_Len   (err_len),
    .o_Overrun   (overrun)
`ifdef PKT_TIMEOUT_EN
    ,
    .o_Err_Timeout (err_tmo)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] len;
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fr[$];
  int checks = 0;
  int errors = 0;
  int n_chk = 0, n_len = 0, n_ovr = 0, n_tmo = 0;
  int cyc = 0;
  int acc_n = 0;
  int acc_cyc [0:127];
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: hold off

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    dv      = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    dv      = 1'b0;
    rx_byte = 8'h00;
  endtask

  // Sends fr[]; a good frame pushes its payload (fr[2..n-2]) to the scoreboard
  task automatic send_frame(input bit good);
    int n;
    n = fr.size();
    if (good) begin
      for (int i = 2; i < n - 1; i++) begin
        sb.push_back({fr[1], (i == n - 2), fr[i]});
      end
    end
    for (int i = 0; i < n; i++) begin
      send(fr[i]);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !pkt_valid) break;
    end
    check("drain_done", sb.size(), 0);
    check("valid_low_idle", {31'd0, pkt_valid}, 0);
    repeat (2) @(posedge clk);
  endtask

  // Ready driver
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor: pulse counting, hold stability and scoreboard compare
  initial begin
    logic       hold;
    logic [7:0] hold_byte;
    logic       hold_last;
    exp_t       e;
    hold = 1'b0;
    hold_byte = 8'h00;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (err_chk) n_chk++;
        if (err_len) n_len++;
        if (overrun) n_ovr++;
`ifdef PKT_TIMEOUT_EN
        if (err_tmo) n_tmo++;
`endif
        if (hold) begin
          check("stable_valid", {31'd0, pkt_valid}, 1);
          check("stable_byte", {24'd0, pkt_byte}, {24'd0, hold_byte});
          check("stable_last", {31'd0, pkt_last}, {31'd0, hold_last});
        end
        if (pkt_valid && ready) begin
          if (sb.size() == 0) begin
            check("unexpected_byte", {31'd0, pkt_valid}, 0);
          end else begin
            e = sb.pop_front();
            check("pkt_byte", {24'd0, pkt_byte}, {24'd0, e.data});
            check("pkt_last", {31'd0, pkt_last}, {31'd0, e.last});
            check("pkt_len", {24'd0, pkt_len}, {24'd0, e.len});
          end
          if (acc_n < 128) acc_cyc[acc_n] = cyc;
          acc_n++;
        end
        hold      = pkt_valid && !ready;
        hold_byte = pkt_byte;
        hold_last = pkt_last;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {31'd0, pkt_valid}, 0);
    check({tag, "_byte"},  {24'd0, pkt_byte}, 0);
    check({tag, "_last"},  {31'd0, pkt_last}, 0);
    check({tag, "_len"},   {24'd0, pkt_len}, 0);
    check({tag, "_errs"},  {29'd0, err_chk, err_len, overrun}, 0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    dv = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Good 3-byte frame, ready always high
    base = acc_n;
    fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_frame(1'b1);
    @(negedge clk);
    check("latency_valid", {31'd0, pkt_valid}, 1);
    wait_idle();
    check("b2b_cycles", acc_cyc[base + 2] - acc_cyc[base], 2);

    // Bad checksum, then a good frame
    fr = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    send_frame(1'b0);
    wait_idle();
    fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_frame(1'b1);
    wait_idle();

    // Length errors
    fr = '{8'hA5, 8'h00};
    send_frame(1'b0);
    wait_idle();
    fr = '{8'hA5, 8'h11};
    send_frame(1'b0);
    wait_idle();

    // Maximum length frame: payload 01..10, checksum 10+88 = 98
    fr = '{8'hA5, 8'h10};
    for (int i = 1; i <= 16; i++) fr.push_back(8'(i));
    fr.push_back(8'h98);
    send_frame(1'b1);
    wait_idle();

    // Backpressure: ready toggling
    ready_mode = 1;
    fr = '{8'hA5, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hEE};
    send_frame(1'b1);
    wait_idle();
    ready_mode = 0;

    // Overrun: SYNC injected while draining is held off
    ready_mode = 2;
    repeat (2) @(posedge clk);
    fr = '{8'hA5, 8'h02, 8'h5A, 8'h5B, 8'hB7};
    send_frame(1'b1);
    send(8'hA5);
    repeat (3) @(posedge clk);
    ready_mode = 0;
    wait_idle();
    fr = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    send_frame(1'b1);
    wait_idle();

    // Noise before SYNC
    fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h42, 8'h43};
    send_frame(1'b0);
    sb.push_back({8'h01, 1'b1, 8'h42});
    wait_idle();

    // Reset in the middle of a payload
    send(8'hA5);
    send(8'h05);
    send(8'h01);
    send(8'h02);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    fr = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h01};
    send_frame(1'b1);
    wait_idle();

`ifdef PKT_TIMEOUT_EN
    // Partial frame then silence
    send(8'hA5);
    send(8'h03);
    send(8'h11);
    repeat (4400) @(posedge clk);
    fr = '{8'hA5, 8'h01, 8'h42, 8'h43};
    send_frame(1'b1);
    wait_idle();
    check("timeout_count", n_tmo, 1);
`endif

    repeat (4) @(posedge clk);
    check("err_chk_count", n_chk, 1);
    check("err_len_count", n_len, 2);
    check("overrun_count", n_ovr, 1);
    check("sb_empty_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
